// File: rtl/block_swap_map.sv
// block_swap_map: SRAM slot residency table that turns lookup misses into swap requests.
// Optional dirty tracking (clean victims skip write-back) is enabled by defining BLOCK_SWAP_MAP_DIRTY_EN.
module block_swap_map #(
  parameter int NumSlots = 4,
  parameter int AddrWidth = 21
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        lookup_valid_i,
  output logic                        lookup_ready_o,
  input  logic [AddrWidth-1:0]        lookup_addr_i,
  input  logic                        lookup_we_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [$clog2(NumSlots)-1:0] rsp_slot_o,
  output logic                        rsp_hit_o,
  output logic                        swap_req_o,
  output logic [$clog2(NumSlots)-1:0] old_addr_idx_o,
  output logic [AddrWidth-1:0]        old_addr_o,
  output logic [AddrWidth-1:0]        new_addr_o,
  output logic                        block_only_load_on_o,
  input  logic                        swap_done_i
);
  localparam int SW = $clog2(NumSlots);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [NumSlots-1:0] valid_q;
  logic [AddrWidth-1:0] tag_q [NumSlots];
  logic [SW-1:0] rr_q, hit_idx, free_idx, victim;
  logic hit, free, evict_q, wb_needed, accept, done;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == lookup_addr_i) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
      if (!valid_q[i]) begin
        free = 1'b1;
        free_idx = SW'(i);
      end
    end
  end
  assign victim = free ? free_idx : rr_q;
  assign accept = state_q == IDLE && lookup_valid_i;
  assign done = state_q == WAIT && swap_done_i;
`ifdef BLOCK_SWAP_MAP_DIRTY_EN
  logic [NumSlots-1:0] dirty_q;
  logic we_q;
  assign wb_needed = dirty_q[victim];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dirty_q <= '0;
      we_q <= 1'b0;
    end else if (accept) begin
      we_q <= lookup_we_i;
      if (hit && lookup_we_i) dirty_q[hit_idx] <= 1'b1;
    end else if (done) begin
      dirty_q[old_addr_idx_o] <= we_q;
    end
  end
`else
  logic unused_we;
  assign unused_we = lookup_we_i;
  assign wb_needed = 1'b1;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NumSlots; i++) tag_q[i] <= '0;
      rr_q <= '0;
      evict_q <= 1'b0;
      rsp_slot_o <= '0;
      rsp_hit_o <= 1'b0;
      old_addr_idx_o <= '0;
      old_addr_o <= '0;
      new_addr_o <= '0;
      block_only_load_on_o <= 1'b0;
    end else if (accept) begin
      rsp_slot_o <= hit ? hit_idx : victim;
      rsp_hit_o <= hit;
      if (!hit) begin
        old_addr_idx_o <= victim;
        old_addr_o <= free ? '0 : tag_q[victim];
        new_addr_o <= lookup_addr_i;
        block_only_load_on_o <= free || !wb_needed;
        evict_q <= !free;
      end
    end else if (done) begin
      valid_q[old_addr_idx_o] <= 1'b1;
      tag_q[old_addr_idx_o] <= new_addr_o;
      rr_q <= evict_q ? rr_q + 1'b1 : rr_q;
    end
  end
  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = lookup_valid_i ? (hit ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = swap_done_i ? RESP : WAIT;
      default: state_d = rsp_ready_i ? IDLE : RESP;
    endcase
  end
  always_comb begin
    lookup_ready_o = state_q == IDLE && !rst_i;
    swap_req_o = state_q == ISSUE;
    rsp_valid_o = state_q == RESP;
  end
endmodule

// File: tb/tb_block_swap_map.sv
// tb_block_swap_map: randomized scoreboard bench for block_swap_map against a table-level reference model.
module tb_block_swap_map;
  localparam int N = 4;
  localparam int AW = 21;
`ifdef BLOCK_SWAP_MAP_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, lookup_valid = 1'b0, lookup_we = 1'b0, rsp_ready = 1'b1, swap_done = 1'b0;
  logic [AW-1:0] lookup_addr = '0;
  logic lookup_ready, rsp_valid, rsp_hit, swap_req, bol;
  logic [1:0] rsp_slot, old_idx;
  logic [AW-1:0] old_addr, new_addr;
  block_swap_map #(.NumSlots(N), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst), .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_addr_i(lookup_addr), .lookup_we_i(lookup_we), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_slot_o(rsp_slot), .rsp_hit_o(rsp_hit), .swap_req_o(swap_req),
    .old_addr_idx_o(old_idx), .old_addr_o(old_addr), .new_addr_o(new_addr),
    .block_only_load_on_o(bol), .swap_done_i(swap_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0;
  function automatic void chk(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  typedef struct {logic [1:0] idx; logic [AW-1:0] old_a; logic [AW-1:0] new_a; logic bol;} swap_t;
  typedef struct {logic [1:0] slot; logic hit;} rsp_t;
  swap_t swap_q[$];
  rsp_t rsp_q[$];
  logic m_valid[N];
  logic m_dirty[N];
  logic [AW-1:0] m_tag[N];
  int m_rr;
  int acc_cyc = 0, done_cyc = 0;
  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i] = '0;
    end
    m_rr = 0;
    swap_q.delete();
    rsp_q.delete();
  endfunction
  // Returns 1 when the lookup needs a swap; pushes the expected swap and response.
  function automatic bit model_lookup(logic [AW-1:0] a, logic we);
    int v;
    v = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == a) begin
        if (DIRTY_EN && we) m_dirty[i] = 1'b1;
        rsp_q.push_back('{2'(i), 1'b1});
        return 1'b0;
      end
    for (int i = 0; i < N; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) begin
      v = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    swap_q.push_back('{2'(v), m_valid[v] ? m_tag[v] : '0, a, !m_valid[v] || (DIRTY_EN && !m_dirty[v])});
    rsp_q.push_back('{2'(v), 1'b0});
    m_valid[v] = 1'b1;
    m_tag[v] = a;
    m_dirty[v] = DIRTY_EN && we;
    return 1'b1;
  endfunction
  function automatic int dups();
    int n;
    n = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (dut.valid_q[i] && dut.valid_q[j] && dut.tag_q[i] == dut.tag_q[j]) n++;
    return n;
  endfunction
  logic prev_valid = 1'b0;
  swap_t es;
  rsp_t er;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (swap_req) begin
        if (swap_q.size() == 0) chk("swap_unexpected", 1, 0);
        else begin
          es = swap_q.pop_front();
          chk("swap_idx", old_idx, es.idx);
          chk("swap_old_addr", old_addr, es.old_a);
          chk("swap_new_addr", new_addr, es.new_a);
          chk("swap_only_load", bol, es.bol);
        end
      end
      if (rsp_valid && !prev_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_latency", cyc, rsp_q[0].hit ? acc_cyc + 1 : done_cyc + 1);
      end
      if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
        er = rsp_q.pop_front();
        chk("rsp_slot", rsp_slot, er.slot);
        chk("rsp_hit", rsp_hit, er.hit);
        chk("dup_tags", dups(), 0);
      end
      prev_valid <= rsp_valid;
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    lookup_valid = 1'b0;
    swap_done = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outs", {lookup_ready, rsp_valid, rsp_slot, rsp_hit, swap_req, old_idx, old_addr, new_addr, bol}, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("ready_after_reset", lookup_ready, 1);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // d < 0 withholds swap_done and resets the design mid-WAIT instead.
  task automatic do_lookup(logic [AW-1:0] a, logic we, int d, int hold);
    bit miss, ok;
    logic [1:0] s;
    logic [44:0] cap;
    rsp_ready = (hold == 0);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      tick();
      ok = lookup_ready;
    end
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      do_reset();
      return;
    end
    lookup_valid = 1'b1;
    lookup_addr = a;
    lookup_we = we;
    acc_cyc = cyc;
    miss = model_lookup(a, we);
    tick();
    lookup_valid = 1'b0;
    if (miss) begin
      ok = 1'b0;
      for (int t = 0; t < 5 && !ok; t++) begin
        ok = swap_req;
        if (!ok) tick();
      end
      if (!ok) begin
        chk("swap_timeout", 0, 1);
        do_reset();
        return;
      end
      chk("swap_latency", cyc, acc_cyc + 1);
      cap = {old_idx, old_addr, new_addr, bol};
      tick();
      chk("swap_pulse_len", swap_req, 0);
      if (d < 0) begin
        repeat (2) tick();
        do_reset();
        return;
      end
      repeat (d) tick();
      swap_done = 1'b1;
      done_cyc = cyc;
      chk("swap_hold", {old_idx, old_addr, new_addr, bol}, cap);
      tick();
      swap_done = 1'b0;
    end else begin
      chk("hit_no_swap", swap_req, 0);
    end
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      ok = rsp_valid;
      if (!ok) tick();
    end
    if (!ok) begin
      chk("rsp_timeout", 0, 1);
      do_reset();
      return;
    end
    s = rsp_slot;
    repeat (hold) begin
      chk("rsp_held", {rsp_valid, rsp_slot, lookup_ready}, {1'b1, s, 1'b0});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("idle_after_rsp", {rsp_valid, lookup_ready}, 2'b01);
  endtask
  initial begin
    logic [AW-1:0] a;
    do_reset();
    do_lookup(21'h10, 1'b0, 20, 0);
    do_lookup(21'h20, 1'b0, 3, 0);
    do_lookup(21'h30, 1'b0, 0, 0);
    do_lookup(21'h40, 1'b0, 1, 0);
    do_lookup(21'h30, 1'b0, 0, 0);
    do_lookup(21'h20, 1'b1, 0, 0);
    do_lookup(21'h50, 1'b0, 2, 0);
    do_lookup(21'h60, 1'b0, 0, 0);
    do_lookup(21'h70, 1'b0, 1, 0);
    do_lookup(21'h80, 1'b0, 0, 0);
    do_lookup(21'h90, 1'b0, 0, 0);
    do_lookup(21'h80, 1'b0, 0, 5);
    swap_done = 1'b1;
    tick();
    swap_done = 1'b0;
    do_lookup(21'h90, 1'b0, 0, 0);
    do_lookup(21'h60, 1'b1, 0, 0);
    repeat (60) begin
      a = ($urandom_range(0, 7) == 7) ? 21'h1FFFFF : 21'($urandom_range(1, 7) * 16);
      do_lookup(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end
    do_lookup(21'h123, 1'b0, -1, 0);
    do_lookup(21'h10, 1'b0, 1, 0);
    tick();
    chk("queues_drained", swap_q.size() + rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
